time_display_scan: RTL and testbench
====================================

# time_display_scan

Downstream consumer of the packed time-of-day counter. Takes the 27-bit hh:mm:ss.ms word (hhhhh mmmmmm ssssss xxxxxxxxxx), snapshots it once per display frame, converts each field to BCD with a serial double-dabble engine, and time-multiplexes eight common-anode 7-segment digits showing HH.MM.SS.cc, where cc is hundreds and tens of ms. Sits between the timer and the board's seven-segment pins.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays lit; 1 ms at 50 MHz. Legal range ≥ 4.
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- time  in  27  packed time: [26:22] hours, [21:16] minutes, [15:10] seconds, [9:0] ms
- an  out  8  digit enables, active-low; an[7] leftmost (hours tens), an[0] ms tens
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame  out  1  one-cycle pulse on each snapshot edge
- busy  out  1  high while BCD conversion runs
- err  out  1  high while committed snapshot is out of range

## Operation
- Prescaler pcnt counts 0..SCAN_DIV-1. Digit index d (0..7) increments mod 8 on the edge where pcnt == SCAN_DIV-1.
- Frame start: the edge where pcnt == SCAN_DIV-1 and d == 7. On that edge: snap <= time, state IDLE→CONV, shift counter <= 0, BCD scratch <= 0. frame is high in the following cycle.
- FSM states: IDLE, CONV, COMMIT.
  - CONV: one double-dabble shift per cycle, fields in order hours (5 shifts), minutes (6), seconds (6), ms (10). Total 27 cycles. Each field has its own BCD scratch: 2 digits for h, m and s; 4 digits for ms. Add-3 correction is applied to a digit ≥ 5 before each shift.
  - COMMIT: one cycle. All eight display digits and err update together, then return to IDLE.
  - busy = (state != IDLE).
- A frame start arriving while not IDLE is ignored: no re-snapshot, and the current conversion finishes.
- Range check on snap: hours > 23, or minutes > 59, or seconds > 59, or ms > 999. If any holds, err is committed to 1 and all digits display dash (g only, seg = 7'h3F). Otherwise err = 0.
- Digit d drives an[7-d]. Digit contents for d = 0..7: H10, H1, M10, M1, S10, S1, ms hundreds, ms tens.
- dp is low (lit) on d = 1, 3, 5; high elsewhere.
- Segment codes (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F.
- No leading-zero blanking.

## Timing
- Reset state:
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame = 0, busy = 0, err = 0.
  - pcnt = 0, d = 0, state IDLE.
  - Display digits reset to all zeros, so the first frame shows 00.00.00.00.
- Reset asserted mid-conversion aborts it. Display digits return to zero and no partial commit occurs.
- an, seg and dp are registered: they reflect d and the display digits from the previous cycle. In the first cycle after reset releases they are still the reset values. From the second cycle, an = 8'h7F.
- Latency: frame-start edge at T. busy is high for cycles T+1 through T+28. The COMMIT edge is at T+28. New digits appear on seg at T+29, gated by the current d.
- The time input is sampled only on the frame-start edge. Changes at any other time have no effect until the next frame.
- Frame period = 8 × SCAN_DIV cycles. With SCAN_DIV ≥ 4, the conversion always finishes before the next frame start.

## Test plan
- Reset: hold reset 5 cycles -> an=FF, seg=7F, dp=1, busy=0, err=0. After release, with SCAN_DIV=4: an steps 7F, BF, DF, … every 4 cycles, and all digits show seg=40.
- Static time 13:45:27.861, SCAN_DIV=4, time = {5'd13, 6'd45, 6'd27, 10'd861} -> after first commit, digits d0..d7 show seg 79, 30, 19, 12, 24, 78, 00, 02. dp is low only on d1, d3, d5. err=0.
- Latency: log the frame pulse and busy -> busy is high for exactly 28 cycles. seg for the current digit changes exactly 1 cycle after busy falls.
- Out of range: hours=24 in one frame, then 23:59:59.999 the next -> first commit gives err=1 and seg=3F on all digits. Second commit gives err=0 and digits 2, 3, 5, 9, 5, 9, 9, 9.
- Snapshot isolation: change time on every cycle between frame starts -> displayed digits equal the value present on the frame-start edge only.
- Reset mid-conversion: assert reset at T+10 -> busy drops, and display digits read 0 after reset releases. The next frame converts normally.

Source files
------------

// File: rtl/time_display_scan.sv
// time_display_scan: snapshots packed hh:mm:ss.ms time_word once per frame, converts each field with a serial double-dabble and scans eight active-low 7-seg digits (an/seg/dp), flagging frame/busy/err
module time_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [26:0] time_word,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame,
  output logic        busy,
  output logic        err
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2;
  localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [PW-1:0] pcnt;
  logic [2:0]    d;
  logic [1:0]    state;
  logic [4:0]    cnt;
  logic [26:0]   snap;
  logic [7:0]    bh, bm, bs;
  logic [15:0]   bms;
  logic [3:0]    disp [8];
  logic          last, start, bad;
  function automatic logic [15:0] dabble(input logic [15:0] v, input logic b);
    logic [15:0] c;
    for (int i = 0; i < 4; i++) c[4*i +: 4] = v[4*i +: 4] >= 4'd5 ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    return 16'({c, b});
  endfunction
  always_comb begin
    last  = pcnt == PW'(SCAN_DIV - 1);
    start = last && d == 3'd7;
    bad   = snap[26:22] > 5'd23 || snap[21:16] > 6'd59 || snap[15:10] > 6'd59 || snap[9:0] > 10'd999;
  end
  assign busy = state != IDLE;
  // snap is rotated through bit 26 during conversion; after 27 rotations it is
  // back to the original word, so the range check at COMMIT sees the snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt  <= '0;
      d     <= '0;
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      bh    <= '0;
      bm    <= '0;
      bs    <= '0;
      bms   <= '0;
      disp  <= '{default: 4'd0};
      err   <= 1'b0;
      frame <= 1'b0;
      an    <= 8'hFF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
    end else begin
      pcnt  <= last ? '0 : pcnt + 1'b1;
      d     <= last ? d + 3'd1 : d;
      frame <= start && state == IDLE;
      an    <= ~(8'h80 >> d);
      seg   <= err ? 7'h3F : CODES[disp[d]];
      dp    <= !(d == 3'd1 || d == 3'd3 || d == 3'd5);
      if (state == IDLE && start) begin
        snap  <= time_word;
        cnt   <= '0;
        bh    <= '0;
        bm    <= '0;
        bs    <= '0;
        bms   <= '0;
        state <= CONV;
      end else if (state == CONV) begin
        snap <= {snap[25:0], snap[26]};
        cnt  <= cnt + 5'd1;
        if (cnt < 5'd5) bh <= 8'(dabble({8'd0, bh}, snap[26]));
        else if (cnt < 5'd11) bm <= 8'(dabble({8'd0, bm}, snap[26]));
        else if (cnt < 5'd17) bs <= 8'(dabble({8'd0, bs}, snap[26]));
        else bms <= dabble(bms, snap[26]);
        state <= cnt == 5'd26 ? COMMIT : CONV;
      end else if (state == COMMIT) begin
        err   <= bad;
        disp  <= '{bh[7:4], bh[3:0], bm[7:4], bm[3:0], bs[7:4], bs[3:0], bms[11:8], bms[7:4]};
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: random and directed stimulus against an arithmetic reference of the scanned clock display
module tb_time_display_scan;
  localparam int SD = 4;
  localparam int FP = 8 * SD;
  localparam logic [6:0] SEGS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] K1 [8] = '{7'h79, 7'h30, 7'h19, 7'h12, 7'h24, 7'h78, 7'h00, 7'h02};
  localparam logic [6:0] K3 [8] = '{7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10, 7'h10, 7'h10};
  localparam logic [26:0] T1 = {5'd13, 6'd45, 6'd27, 10'd861};
  localparam logic [26:0] T2 = {5'd24, 6'd0, 6'd0, 10'd0};
  localparam logic [26:0] T3 = {5'd23, 6'd59, 6'd59, 10'd999};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [26:0] time_word = '0;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp, frame, busy, err;
  int checks = 0, errors = 0;
  int n = 0, t_fs = -1000, bcnt = 0, known = 0;
  bit inflight = 0, merr = 0;
  int mdig [8];
  logic [26:0] snapped = '0;

  time_display_scan #(.SCAN_DIV(SD)) dut (
    .clock(clock), .reset(reset), .time_word(time_word),
    .an(an), .seg(seg), .dp(dp), .frame(frame), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [26:0] rnd_time();
    logic [4:0] h;
    logic [5:0] m, s;
    logic [9:0] ms;
    h  = ($urandom % 8 == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
    m  = ($urandom % 8 == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
    s  = ($urandom % 8 == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
    ms = ($urandom % 8 == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 999));
    return {h, m, s, ms};
  endfunction

  task automatic mreset();
    n = 0;
    t_fs = -1000;
    inflight = 0;
    merr = 0;
    known = 0;
    bcnt = 0;
    for (int i = 0; i < 8; i++) mdig[i] = 0;
  endtask

  task automatic commit();
    int h, m, s, ms;
    h  = int'(snapped[26:22]);
    m  = int'(snapped[21:16]);
    s  = int'(snapped[15:10]);
    ms = int'(snapped[9:0]);
    merr = h > 23 || m > 59 || s > 59 || ms > 999;
    mdig = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10, (ms / 100) % 10, (ms / 10) % 10};
    known = snapped == T1 ? 1 : snapped == T2 ? 2 : snapped == T3 ? 3 : 0;
    inflight = 0;
  endtask

  task automatic model_edge();
    int dd;
    logic [7:0] ea;
    logic [6:0] es;
    dd = (n / SD) % 8;
    if (n % FP == FP - 1) begin
      snapped = time_word;
      t_fs = n;
      inflight = 1;
    end
    ea = ~(8'h80 >> dd);
    es = merr ? 7'h3F : SEGS[mdig[dd]];
    check("an", an, ea);
    check("seg", seg, es);
    check("dp", dp, (dd == 1 || dd == 3 || dd == 5) ? 0 : 1);
    check("frame", frame, inflight && n == t_fs);
    check("busy", busy, inflight && n >= t_fs && n <= t_fs + 27);
    if (known == 1) check("seg_13:45:27.861", seg, K1[dd]);
    if (known == 2) check("seg_dash", seg, 7'h3F);
    if (known == 3) check("seg_23:59:59.999", seg, K3[dd]);
    if (inflight && n == t_fs + 28) commit();
    check("err", err, merr);
    if (busy) bcnt++;
    else if (bcnt != 0) begin
      check("busy_len", bcnt, 28);
      bcnt = 0;
    end
    n++;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1);
      check("rst_frame", frame, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      mreset();
    end
  endtask

  task automatic run(input int cycles, input bit rnd, input logic [26:0] val);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      reset = 1'b0;
      time_word = rnd ? rnd_time() : val;
      @(posedge clock);
      #1;
      model_edge();
    end
  endtask

  initial begin
    mreset();
    do_reset(5);
    run(2 * FP, 0, T1);
    run(FP, 0, T2);
    run(FP, 0, T3);
    run(6 * FP, 1, '0);
    run(10, 1, '0);
    do_reset(3);
    run(3 * FP, 1, '0);
    run(2 * FP, 0, T1);
    run(FP, 0, T3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
